apb_slave_ctrl: RTL

APB3 slave transfer controller for the SPI peripheral: runs the SETUP/ACCESS handshake, inserts wait states while the SPI core is busy, and detects access errors. It issues single-cycle register strobes into the SPI register file. It produces the real PREADY/PSLVERR completion response, replacing the constant-zero error path. It sits directly between the APB bus and the SPI register block.

---
 rtl/apb_slave_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/apb_slave_ctrl.sv
// apb_slave_ctrl: APB3 slave transfer controller in front of the SPI register file.
// Runs SETUP/ACCESS, stalls while spi_busy, decodes errors, drives PREADY/PSLVERR.
//
// Ports:
//   PCLK, PRESETn          clock, synchronous active-low reset
//   PSEL..PWDATA           APB3 request
//   PRDATA, PREADY,
//   PSLVERR                APB3 response (PSLVERR only with PREADY)
//   spi_busy               SPI core cannot take a register access now
//   reg_addr, reg_wdata    captured word index / write data
//   reg_wr_en, reg_rd_en   one-cycle register strobes
//   reg_rdata              combinational read data for reg_addr
//   err_cause              0 ok, 1 bad address, 2 read-only write, 3 timeout
//
// Build option: define APB_SLV_TIMEOUT_EN to bound busy waits by TIMEOUT cycles.
module apb_slave_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic              spi_busy,
    output logic [1:0]        reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic [1:0]        err_cause
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [1:0] E_OK   = 2'd0;
    localparam logic [1:0] E_ADDR = 2'd1;
    localparam logic [1:0] E_RO   = 2'd2;

    state_t     state;
    state_t     state_nx;
    logic       h_write;
    logic [1:0] h_err;
    logic [1:0] h_err_nx;
    logic [1:0] dec_err;
    logic       bad_addr;
    logic       ro_write;
    logic       setup;
    logic       fire;

    // STATUS (0x04) and RXDATA (0x0C) both have PADDR[2] set.
    assign bad_addr = (PADDR[1:0] != 2'b00) ||
                      (PADDR > ADDR_W'('hC));
    assign ro_write = !bad_addr && PWRITE && PADDR[2];

    always_comb begin
        dec_err = E_OK;
        unique case (1'b1)
            bad_addr: dec_err = E_ADDR;
            ro_write: dec_err = E_RO;
            default:  dec_err = E_OK;
        endcase
    end

    assign setup = (state == S_IDLE) && PSEL && !PENABLE;

`ifdef APB_SLV_TIMEOUT_EN
    localparam logic [1:0] E_TMO = 2'd3;
    localparam int         CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wcnt;
    logic             cnt_inc;

    // Saturating: stops at CNT_MAX, never wraps.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            wcnt <= '0;
        end else if (setup) begin
            wcnt <= '0;
        end else if (cnt_inc && wcnt != CNT_MAX) begin
            wcnt <= wcnt + 1'b1;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT > 1);
`endif

    always_comb begin
        state_nx = state;
        h_err_nx = h_err;
        fire     = 1'b0;
`ifdef APB_SLV_TIMEOUT_EN
        cnt_inc  = 1'b0;
`endif
        unique case (state)
            S_IDLE: begin
                if (setup) begin
                    state_nx = S_WAIT;
                    h_err_nx = dec_err;
                end
            end
            S_WAIT: begin
                if (!PSEL) begin
                    state_nx = S_IDLE;
                end else if (h_err != E_OK) begin
                    state_nx = S_RESP;
                end else if (!spi_busy) begin
                    fire     = 1'b1;
                    state_nx = S_RESP;
                end
`ifdef APB_SLV_TIMEOUT_EN
                else if (wcnt == CNT_MAX) begin
                    state_nx = S_RESP;
                    h_err_nx = E_TMO;
                end else begin
                    cnt_inc = 1'b1;
                end
`endif
            end
            S_RESP: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Gated by reset so an edge that resets the block never writes.
    assign reg_wr_en = fire && h_write && PRESETn;
    assign reg_rd_en = fire && !h_write && PRESETn;

    assign PREADY  = (state == S_RESP);
    assign PSLVERR = (state == S_RESP) && (h_err != E_OK);

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state     <= S_IDLE;
            h_write   <= 1'b0;
            h_err     <= E_OK;
            reg_addr  <= '0;
            reg_wdata <= '0;
            PRDATA    <= '0;
            err_cause <= E_OK;
        end else begin
            state <= state_nx;
            h_err <= h_err_nx;
            if (setup) begin
                h_write   <= PWRITE;
                reg_addr  <= PADDR[3:2];
                reg_wdata <= PWDATA;
            end
            if (fire && !h_write) begin
                PRDATA <= reg_rdata;
            end
            if (state == S_RESP) begin
                err_cause <= h_err;
            end
        end
    end

endmodule
